reg_wb_arbiter: RTL

//  Owns the register file's single write port: round-robins write-back requests

---
 rtl/rf_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/reg_wb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back FSM state type.
// Imported by the write-back arbiter and its round-robin selector.
package rf_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_e;

    // Index width for n requesters; never zero so a single-bit pointer still exists.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr_i, with wrap.
// The pointer register itself lives in the caller.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o
);

    logic             found;
    int               pos;
    logic [PTR_W-1:0] pos_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        pos         = 0;
        pos_idx     = '0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = PTR_W'(pos);
            if (!found && req_i[pos_idx]) begin
                found            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                grant_idx_o      = pos_idx;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Sole owner of the register file write port: clears x1..x(2**ADDR_W-1) after reset,
// then round-robins write-back requests onto a registered write port.
module reg_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int ADDR_W  = rf_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic                      init_busy
);

    localparam int                PTR_W   = ptr_w(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_RD = {ADDR_W{1'b1}};
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_REQ - 1);

    wb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Grant is one-hot, so a priority-free select is enough.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake: a requester raises valid and holds rd/data until it sees ready in the
    // same cycle; valid & ready at a rising edge is one transfer. Ready is never given in INIT.
    assign req_ready = (state_q == RUN) ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        wr_d      = 1'b0;
        rd_d      = rd_q;
        data_d    = data_q;
        case (state_q)
            INIT: begin
                wr_d      = 1'b1;
                rd_d      = clr_cnt_q;
                data_d    = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_RD) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    // x0 is hard-wired zero: consume the request but suppress the write.
                    wr_d     = |sel_rd;
                    rd_d     = sel_rd;
                    data_d   = sel_data;
                    rr_ptr_d = (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= INIT;
            clr_cnt_q <= ADDR_W'(1);
            rr_ptr_q  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign rf_reg_write  = wr_q;
    assign rf_rd         = rd_q;
    assign rf_write_data = data_q;
    assign init_busy     = (state_q == INIT);

endmodule
